// File: rtl/axi_write_burst_sequencer.sv
// Splits a (start address, byte count) write command into 4 KB-safe AXI4 INCR bursts with per-beat lane strobes.
// AW one cycle after accept, W only after the AW handshake, B after WLAST; W and SRC are combinationally coupled so stalls pass straight through.
module axi_write_burst_sequencer #(
  parameter int DATA_BYTES = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 32,
  parameter int MAX_BURST  = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [LEN_WIDTH-1:0]    CMD_BYTES,
  input  logic [8*DATA_BYTES-1:0] SRC_DATA,
  input  logic                    SRC_VALID,
  output logic                    SRC_READY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [8*DATA_BYTES-1:0] WDATA,
  output logic [DATA_BYTES-1:0]   WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state, next_state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [7:0]            beat_cnt;
  logic [14:0]           burst_cap;
  logic [LEN_WIDTH-1:0]  burst_bytes, next_rem;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last_burst;
  logic [5:0]            end_lo;
  logic [DATA_BYTES-1:0] first_mask, last_mask;
  logic                  unused_bresp0;

  assign unused_bresp0 = BRESP[0];
  assign AWSIZE  = 3'b110;
  assign AWBURST = 2'b01;

  // Beats for a burst starting at addr_lo: capped by MAX_BURST, the 4 KB page and the bytes left.
  function automatic logic [7:0] calc_len(input logic [11:0] addr_lo, input logic [LEN_WIDTH-1:0] rem);
    logic [LEN_WIDTH+1:0] need;
    logic [6:0]           to_4k;
    logic [8:0]           beats;
    need  = ((LEN_WIDTH+2)'(rem) + (LEN_WIDTH+2)'(addr_lo[5:0]) + (LEN_WIDTH+2)'(63)) >> 6;
    to_4k = 7'd64 - {1'b0, addr_lo[11:6]};
    beats = 9'(MAX_BURST);
    if ({2'b00, to_4k} < beats) beats = {2'b00, to_4k};
    if (need < (LEN_WIDTH+2)'(beats)) beats = 9'(need);
    return 8'(beats - 9'd1);
  endfunction

  // Bytes the current burst can carry; if the rest fits, this is the command's final burst.
  assign burst_cap   = {({1'b0, AWLEN} + 9'd1), 6'd0} - {9'd0, AWADDR[5:0]};
  assign last_burst  = remaining <= LEN_WIDTH'(burst_cap);
  assign burst_bytes = last_burst ? remaining : LEN_WIDTH'(burst_cap);
  assign next_rem    = remaining - burst_bytes;
  assign next_addr   = AWADDR + ADDR_WIDTH'(burst_bytes);
  assign end_lo      = AWADDR[5:0] + remaining[5:0];

  assign first_mask = (beat_cnt == 8'd0) ? ({DATA_BYTES{1'b1}} << AWADDR[5:0]) : {DATA_BYTES{1'b1}};
  assign last_mask  = (last_burst && beat_cnt == AWLEN && end_lo != 6'd0) ?
                      ~({DATA_BYTES{1'b1}} << end_lo) : {DATA_BYTES{1'b1}};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    CMD_READY  = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    SRC_READY  = 1'b0;
    WDATA      = '0;
    WSTRB      = '0;
    WLAST      = 1'b0;
    BREADY     = 1'b0;
    BUSY       = (state != IDLE);
    case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID && CMD_BYTES != '0) next_state = ADDR;
      end
      ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) next_state = DATA;
      end
      DATA: begin
        WVALID    = SRC_VALID;
        SRC_READY = WREADY;
        WDATA     = SRC_DATA;
        WSTRB     = first_mask & last_mask;
        WLAST     = (beat_cnt == AWLEN);
        if (SRC_VALID && WREADY && beat_cnt == AWLEN) next_state = RESP;
      end
      RESP: begin
        BREADY = 1'b1;
        if (BVALID) next_state = (next_rem == '0) ? IDLE : ADDR;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      AWADDR    <= '0;
      AWLEN     <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (CMD_VALID) begin
          ERROR     <= 1'b0;
          AWADDR    <= CMD_ADDR;
          remaining <= CMD_BYTES;
          AWLEN     <= calc_len(CMD_ADDR[11:0], CMD_BYTES);
          if (CMD_BYTES == '0) DONE <= 1'b1;
        end
        ADDR: if (AWREADY) beat_cnt <= '0;
        DATA: if (SRC_VALID && WREADY) beat_cnt <= beat_cnt + 8'd1;
        RESP: if (BVALID) begin
          if (BRESP[1]) ERROR <= 1'b1;
          AWADDR    <= next_addr;
          remaining <= next_rem;
          if (next_rem == '0) DONE  <= 1'b1;
          else                AWLEN <= calc_len(next_addr[11:0], next_rem);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi_write_burst_sequencer.md
Name: axi_write_burst_sequencer

Overview:
- Sequences AXI4 write transactions on the 512-bit (64-byte) host-memory master port of the accelerator.
- Takes one command (start byte address, byte count) plus a lane-aligned data stream. Splits the command into INCR bursts that respect the 4 KB boundary and a maximum burst length.
- Drives AW, W and B channels and generates the per-beat WSTRB byte enables for partial first and last beats.
- Sits between the kernel's output stream and the shell's AXI master interface.

Parameters:
- DATA_BYTES, 64, bus width in bytes (fixed at 64 for this block; WSTRB width).
- ADDR_WIDTH, 64, AXI address width.
- LEN_WIDTH, 32, width of the command byte count.
- MAX_BURST, 64, maximum beats per burst (1..256).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command accepted when high with CMD_VALID.
- CMD_ADDR  in  ADDR_WIDTH  start byte address (any alignment).
- CMD_BYTES  in  LEN_WIDTH  byte count.
- SRC_DATA  in  512  data beat, bytes already in their AXI lane positions.
- SRC_VALID  in  1  source beat valid.
- SRC_READY  out  1  source beat consumed.
- AWADDR  out  ADDR_WIDTH.  AWLEN  out  8.  AWSIZE  out  3.  AWBURST  out  2.
- AWVALID  out  1.  AWREADY  in  1.
- WDATA  out  512.  WSTRB  out  64.  WLAST  out  1.
- WVALID  out  1.  WREADY  in  1.
- BRESP  in  2.  BVALID  in  1.  BREADY  out  1.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse when the command completes.
- ERROR  out  1  sticky SLVERR/DECERR flag for the current command.

Behaviour:
- Reset: state IDLE. AWVALID, WVALID, BREADY, DONE, ERROR, BUSY = 0; AWADDR, AWLEN = 0. CMD_READY = 1 the first cycle after RST deasserts.
- Reset mid-operation: abandons the burst with no further beats, outputs go to reset values the next cycle. Shell-wide reset makes this legal.
- AWSIZE is constantly 3'b110; AWBURST is constantly 2'b01 (INCR).
- States and transitions:
  - IDLE: CMD_READY = 1. On CMD_VALID, latch cur_addr = CMD_ADDR, remaining = CMD_BYTES, clear ERROR, go to ADDR.
  - CMD_BYTES = 0: no AXI traffic; DONE pulses the next cycle; stay IDLE.
  - ADDR: AWVALID registered high one cycle after accept, held with AWADDR/AWLEN stable until AWREADY.
  - Burst size: beats = min(MAX_BURST, 64 - cur_addr[11:6], ceil((cur_addr[5:0] + remaining)/64)). AWADDR = cur_addr (unaligned allowed). AWLEN = beats-1.
  - After the AW handshake, go to DATA. No W beat is issued before the AW handshake, and AW and W never overlap.
  - DATA: WVALID = SRC_VALID, SRC_READY = WREADY, WDATA = SRC_DATA (combinational pass-through, state-gated). A beat counter advances on WVALID & WREADY. WLAST is high on beat index AWLEN. After the WLAST handshake, go to RESP.
  - RESP: BREADY = 1. On BVALID, if BRESP[1] is set then ERROR <= 1. Update cur_addr += burst bytes and remaining -= burst bytes, where burst bytes = min(remaining, beats*64 - cur_addr[5:0]). If remaining == 0, pulse DONE and go to IDLE; otherwise go to ADDR.
  - Errors do not abort the command; all remaining bursts are still issued.
- WSTRB (bit i = byte lane i):
  - First beat of a command: lanes >= start[5:0].
  - Last beat of a command: lanes < end[5:0], where end = start + CMD_BYTES; all lanes if end[5:0] = 0.
  - Single-beat command: AND of the two.
  - All other beats: all ones.
  - Bursts after the first in a command always start 64-byte aligned.
- Latency:
  - Accept at cycle N → AWVALID at N+1.
  - AW handshake at M → WVALID may assert at M+1.
  - WLAST handshake at K → BREADY at K+1.
  - B handshake at J → next AWVALID or DONE at J+1.
- Arithmetic: remaining and burst-byte math is LEN_WIDTH wide. Addresses wrap modulo 2^ADDR_WIDTH (no special handling).

Test Plan:
- ADDR 0x1000, 256 bytes → one AW (AWADDR 0x1000, AWLEN 3). 4 beats with WSTRB all ones, WLAST on beat 4, then one B, then DONE.
- ADDR 0x1003, 10 bytes → AWLEN 0, WSTRB 0x0000_0000_0000_1FF8, WLAST on beat 1.
- ADDR 0x0FC0, 128 bytes (4K crossing) → burst 1: AWADDR 0x0FC0, AWLEN 0. Burst 2: AWADDR 0x1000, AWLEN 0. Both beats all-ones WSTRB, one DONE.
- ADDR 0x0, 5000 bytes → burst 1: AWADDR 0x0, AWLEN 63. Burst 2: AWADDR 0x1000, AWLEN 14, last WSTRB 0x00..00FF.
- AWREADY delayed 5 cycles, SRC_VALID toggling, WREADY low 3 cycles → AWVALID/AWADDR stable while waiting. No WVALID before the AW handshake. Beat count and data order unchanged.
- 2-burst command with BRESP = 2'b10 on burst 1 → burst 2 is still issued, ERROR = 1 at DONE, cleared on the next accept. RST during DATA → next cycle WVALID = 0, CMD_READY = 1.
